// File: rtl/deint_pkg.sv
// Shared constants and the interleaver index mapping for the block de-interleaver.
package deint_pkg;

    localparam int DEINT_ROWS = 8;
    localparam int DEINT_COLS = 8;
    localparam int DEINT_N    = DEINT_ROWS * DEINT_COLS;
    localparam int DEINT_AW   = $clog2(DEINT_N);

    // Interleaved input index k lands at original position
    // (k mod rows) * cols + (k div rows). For powers of 2 this is a bit swap.
    function automatic int deint_wr_pos(input int k,
                                        input int rows = DEINT_ROWS,
                                        input int cols = DEINT_COLS);
        return (k % rows) * cols + (k / rows);
    endfunction

endpackage

// File: rtl/deint_bank.sv
// One N-bit block buffer: bit-wide write port, asynchronous read port and a
// full flag that marks the bank as owned by the read side.
module deint_bank #(
    parameter int N  = 64,
    parameter int AW = $clog2(N)
) (
    input  logic          clk2,
    input  logic          rst,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic          wbit_i,
    input  logic [AW-1:0] raddr_i,
    output logic          rbit_o,
    input  logic          set_i,
    input  logic          clr_i,
    output logic          full_o
);

    logic [N-1:0] mem_q;
    logic         full_q;
    logic         full_d;

    // Storage has no reset; contents are only meaningful once the bank is full.
    always_ff @(posedge clk2) begin
        if (we_i) mem_q[waddr_i] <= wbit_i;
    end

    // Set and clear never hit the same bank in one cycle, so priority is moot.
    always_comb begin
        full_d = full_q;
        if (set_i)      full_d = 1'b1;
        else if (clr_i) full_d = 1'b0;
    end

    // Full flag register.
    always_ff @(posedge clk2) begin
        if (rst) full_q <= 1'b0;
        else     full_q <= full_d;
    end

    assign rbit_o = mem_q[raddr_i];
    assign full_o = full_q;

endmodule

// File: rtl/deinterleaver.sv
// Block de-interleaver: ping-pong banks, scattered writes, sequential reads,
// ready/valid output register with per-block last marker, sticky overflow.
module deinterleaver
    import deint_pkg::*;
#(
    parameter int ROWS = DEINT_ROWS,
    parameter int COLS = DEINT_COLS
) (
    input  logic clk2,
    input  logic rst,
    input  logic din,
    input  logic din_valid,
    output logic din_ready,
    output logic dout,
    output logic dout_valid,
    input  logic dout_ready,
    output logic dout_last,
    output logic overflow
);

    localparam int N  = ROWS * COLS;
    localparam int AW = $clog2(N);

    logic          wr_bank_q, wr_bank_d;
    logic [AW-1:0] wr_cnt_q,  wr_cnt_d;
    logic          rd_bank_q, rd_bank_d;
    logic [AW-1:0] rd_cnt_q,  rd_cnt_d;
    logic          dout_q, dout_d;
    logic          dout_valid_q, dout_valid_d;
    logic          dout_last_q, dout_last_d;
    logic          overflow_q, overflow_d;

    logic [1:0]    full, rbit, bank_we, bank_set, bank_clr;
    logic [AW-1:0] wr_pos;
    logic          accept, drop, wr_last, rd_last, load;

    // Decisions use the registered full flags only, so a bank freed at an
    // edge is writable from the following cycle.
    assign accept  = din_valid && !full[wr_bank_q];
    assign drop    = din_valid &&  full[wr_bank_q];
    assign wr_last = (wr_cnt_q == AW'(N - 1));
    assign rd_last = (rd_cnt_q == AW'(N - 1));
    assign load    = full[rd_bank_q] && (!dout_valid_q || dout_ready);
    assign wr_pos  = AW'(deint_wr_pos(int'(wr_cnt_q), ROWS, COLS));

    // Steer write/set to the write bank and clear to the read bank.
    always_comb begin
        bank_we  = '0;
        bank_set = '0;
        bank_clr = '0;
        bank_we[wr_bank_q]  = accept;
        bank_set[wr_bank_q] = accept && wr_last;
        bank_clr[rd_bank_q] = load && rd_last;
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        deint_bank #(.N(N), .AW(AW)) u_bank (
            .clk2    (clk2),
            .rst     (rst),
            .we_i    (bank_we[b]),
            .waddr_i (wr_pos),
            .wbit_i  (din),
            .raddr_i (rd_cnt_q),
            .rbit_o  (rbit[b]),
            .set_i   (bank_set[b]),
            .clr_i   (bank_clr[b]),
            .full_o  (full[b])
        );
    end

    // Next state for counters, bank pointers, output register and overflow.
    always_comb begin
        wr_bank_d    = wr_bank_q;
        wr_cnt_d     = wr_cnt_q;
        rd_bank_d    = rd_bank_q;
        rd_cnt_d     = rd_cnt_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        dout_last_d  = dout_last_q;
        overflow_d   = overflow_q || drop;
        if (accept) begin
            if (wr_last) begin
                wr_cnt_d  = '0;
                wr_bank_d = !wr_bank_q;
            end else begin
                wr_cnt_d  = wr_cnt_q + 1'b1;
            end
        end
        if (load) begin
            dout_d       = rbit[rd_bank_q];
            dout_valid_d = 1'b1;
            dout_last_d  = rd_last;
            if (rd_last) begin
                rd_cnt_d  = '0;
                rd_bank_d = !rd_bank_q;
            end else begin
                rd_cnt_d  = rd_cnt_q + 1'b1;
            end
        end else if (dout_ready) begin
            dout_valid_d = 1'b0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk2) begin
        if (rst) begin
            wr_bank_q    <= 1'b0;
            wr_cnt_q     <= '0;
            rd_bank_q    <= 1'b0;
            rd_cnt_q     <= '0;
            dout_q       <= 1'b0;
            dout_valid_q <= 1'b0;
            dout_last_q  <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            wr_bank_q    <= wr_bank_d;
            wr_cnt_q     <= wr_cnt_d;
            rd_bank_q    <= rd_bank_d;
            rd_cnt_q     <= rd_cnt_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            dout_last_q  <= dout_last_d;
            overflow_q   <= overflow_d;
        end
    end

    assign din_ready  = !full[wr_bank_q];
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign dout_last  = dout_last_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_deinterleaver.sv
// Directed bench for the 8x8 block de-interleaver.
module tb_deinterleaver;

    logic clk2 = 1'b0;
    logic rst, din, din_valid, din_ready, dout, dout_valid, dout_ready, dout_last, overflow;

    int total = 0;
    int bad   = 0;

    bit q_bits[$];
    bit q_last[$];

    deinterleaver #(.ROWS(8), .COLS(8)) dut (
        .clk2       (clk2),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_last  (dout_last),
        .overflow   (overflow)
    );

    always #5 clk2 = ~clk2;

    // Record every output transfer that will complete at the next rising edge.
    always @(negedge clk2) begin
        if (!rst && dout_valid === 1'b1 && dout_ready === 1'b1) begin
            q_bits.push_back(dout);
            q_last.push_back(dout_last);
        end
    end

    // Reference 8x8 interleaver: write rows, read columns.
    function automatic logic [63:0] ilv(input logic [63:0] d);
        logic [63:0] s;
        for (int k = 0; k < 64; k++) s[k] = d[(k % 8) * 8 + (k / 8)];
        return s;
    endfunction

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk2);
            #1;
        end
    endtask

    task automatic send_block(input logic [63:0] s, input bit gaps);
        for (int k = 0; k < 64; k++) begin
            if (gaps) begin
                while ($urandom_range(1, 0) == 0) begin
                    din_valid = 1'b0;
                    tick(1);
                end
            end
            din       = s[k];
            din_valid = 1'b1;
            tick(1);
        end
        din_valid = 1'b0;
        din       = 1'b0;
    endtask

    task automatic pop_block(output logic [63:0] b, output logic [63:0] l);
        b = 'x;
        l = 'x;
        for (int i = 0; i < 64; i++) begin
            if (q_bits.size() > 0) begin
                b[i] = q_bits.pop_front();
                l[i] = q_last.pop_front();
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; din = 1'b0; din_valid = 1'b0; dout_ready = 1'b0;
        tick(2);
        rst = 1'b0;
        total++; if (dout !== 1'b0)       begin bad++; $display("FAIL reset_dout got=%b exp=0", dout); end
        total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL reset_dout_valid got=%b exp=0", dout_valid); end
        total++; if (dout_last !== 1'b0)  begin bad++; $display("FAIL reset_dout_last got=%b exp=0", dout_last); end
        total++; if (overflow !== 1'b0)   begin bad++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
        total++; if (din_ready !== 1'b1)  begin bad++; $display("FAIL reset_din_ready got=%b exp=1", din_ready); end
        q_bits.delete(); q_last.delete();
    endtask

    task automatic test_impulse();
        logic [63:0] b, l;
        dout_ready = 1'b1;
        send_block(64'h2, 1'b0);
        // Right after the edge that took k=63: full set, output not yet loaded.
        total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL impulse_lat1 dout_valid got=%b exp=0", dout_valid); end
        tick(1);
        total++; if (dout_valid !== 1'b1) begin bad++; $display("FAIL impulse_lat2 dout_valid got=%b exp=1", dout_valid); end
        tick(70);
        total++; if (q_bits.size() != 64) begin bad++; $display("FAIL impulse_count got=%0d exp=64", q_bits.size()); end
        pop_block(b, l);
        total++; if (b !== 64'h100) begin bad++; $display("FAIL impulse_data got=%h exp=%h", b, 64'h100); end
        total++; if (l !== 64'h8000_0000_0000_0000) begin bad++; $display("FAIL impulse_last got=%h exp=8000000000000000", l); end
    endtask

    task automatic test_round_trip();
        logic [63:0] d [20];
        logic [63:0] b, l;
        dout_ready = 1'b1;
        for (int i = 0; i < 20; i++) d[i] = {$urandom(), $urandom()};
        for (int i = 0; i < 20; i++) send_block(ilv(d[i]), 1'b0);
        tick(70);
        total++; if (q_bits.size() != 1280) begin bad++; $display("FAIL rt_count got=%0d exp=1280", q_bits.size()); end
        for (int i = 0; i < 20; i++) begin
            pop_block(b, l);
            total++; if (b !== d[i]) begin bad++; $display("FAIL rt_data blk=%0d got=%h exp=%h", i, b, d[i]); end
            total++; if (l !== 64'h8000_0000_0000_0000) begin bad++; $display("FAIL rt_last blk=%0d got=%h exp=8000000000000000", i, l); end
        end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rt_overflow got=%b exp=0", overflow); end
    endtask

    task automatic test_gaps();
        logic [63:0] d [3];
        logic [63:0] b, l;
        dout_ready = 1'b1;
        d[0] = 64'h0123_4567_89AB_CDEF;
        d[1] = 64'hFFFF_0000_AAAA_5555;
        d[2] = 64'h8000_0000_0000_0001;
        for (int i = 0; i < 3; i++) send_block(ilv(d[i]), 1'b1);
        tick(70);
        total++; if (q_bits.size() != 192) begin bad++; $display("FAIL gaps_count got=%0d exp=192", q_bits.size()); end
        for (int i = 0; i < 3; i++) begin
            pop_block(b, l);
            total++; if (b !== d[i]) begin bad++; $display("FAIL gaps_data blk=%0d got=%h exp=%h", i, b, d[i]); end
        end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL gaps_overflow got=%b exp=0", overflow); end
    endtask

    task automatic test_backpressure();
        logic [63:0] d [3];
        logic [63:0] b, l;
        logic        held;
        d[0] = 64'hDEAD_BEEF_0BAD_F00D;
        d[1] = 64'h1357_9BDF_2468_ACE1;
        d[2] = 64'hFFFF_FFFF_FFFF_FFFF;
        dout_ready = 1'b0;
        send_block(ilv(d[0]), 1'b0);
        total++; if (din_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_after1 got=%b exp=1", din_ready); end
        send_block(ilv(d[1]), 1'b0);
        total++; if (din_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_after2 got=%b exp=0", din_ready); end
        total++; if (dout_valid !== 1'b1) begin bad++; $display("FAIL bp_hold_valid got=%b exp=1", dout_valid); end
        held = dout;
        total++; if (held !== d[0][0]) begin bad++; $display("FAIL bp_hold_dout got=%b exp=%b", held, d[0][0]); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL bp_ovf_before got=%b exp=0", overflow); end
        send_block(ilv(d[2]), 1'b0);
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL bp_ovf_after got=%b exp=1", overflow); end
        tick(8);
        total++; if (dout !== d[0][0] || dout_valid !== 1'b1 || dout_last !== 1'b0) begin
            bad++; $display("FAIL bp_stable got=%b/%b/%b exp=%b/1/0", dout, dout_valid, dout_last, d[0][0]);
        end
        total++; if (q_bits.size() != 0) begin bad++; $display("FAIL bp_no_xfer got=%0d exp=0", q_bits.size()); end
        dout_ready = 1'b1;
        tick(140);
        total++; if (q_bits.size() != 128) begin bad++; $display("FAIL bp_count got=%0d exp=128", q_bits.size()); end
        for (int i = 0; i < 2; i++) begin
            pop_block(b, l);
            total++; if (b !== d[i]) begin bad++; $display("FAIL bp_data blk=%0d got=%h exp=%h", i, b, d[i]); end
        end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL bp_ovf_sticky got=%b exp=1", overflow); end
    endtask

    task automatic test_reset_mid();
        logic [63:0] s1, s2, d3;
        logic [63:0] b, l;
        s1 = ilv(64'hCAFE_BABE_1234_5678);
        s2 = ilv(64'h5A5A_A5A5_0F0F_F0F0);
        d3 = 64'h0F1E_2D3C_4B5A_6978;
        rst = 1'b1; tick(1); rst = 1'b0;
        dout_ready = 1'b1;
        send_block(s1, 1'b0);
        for (int k = 0; k < 30; k++) begin
            din = s2[k]; din_valid = 1'b1; tick(1);
        end
        din = s2[30]; rst = 1'b1; tick(1);
        rst = 1'b0; din_valid = 1'b0; din = 1'b0;
        total++; if (dout_valid !== 1'b0 || dout !== 1'b0 || dout_last !== 1'b0) begin
            bad++; $display("FAIL rstmid_out got=%b/%b/%b exp=0/0/0", dout_valid, dout, dout_last);
        end
        total++; if (overflow !== 1'b0 || din_ready !== 1'b1) begin
            bad++; $display("FAIL rstmid_flags ovf=%b rdy=%b exp ovf=0 rdy=1", overflow, din_ready);
        end
        q_bits.delete(); q_last.delete();
        send_block(ilv(d3), 1'b0);
        tick(70);
        total++; if (q_bits.size() != 64) begin bad++; $display("FAIL rstmid_count got=%0d exp=64", q_bits.size()); end
        pop_block(b, l);
        total++; if (b !== d3) begin bad++; $display("FAIL rstmid_data got=%h exp=%h", b, d3); end
        total++; if (l !== 64'h8000_0000_0000_0000) begin bad++; $display("FAIL rstmid_last got=%h exp=8000000000000000", l); end
    endtask

    initial begin
        test_reset();
        test_impulse();
        test_round_trip();
        test_gaps();
        test_backpressure();
        test_reset();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
